sys_bus_arbiter: RTL and testbench
==================================

// Module: sys_bus_arbiter
// PURPOSE
// Shares the single-port 256x32 main memory between NUM_REQ bus masters (CPU, DMA, debug).
// Round-robin grant; each granted transfer is sequenced through address-latch, transfer and
// complete phases, driving the memory's addr/write_en/read_en/write_in. Read data and a
// one-cycle done pulse go back to the owning master. Sits between the masters and MEM_256bytes.
// PARAMETERS
// NUM_REQ     4   number of masters (2..8)
// ADDR_WIDTH  8   memory address width (= log2 memory depth)
// DATA_WIDTH  32  data word width (= memory width)
// RD_LAT      1   cycles from mem_read_en to valid mem_read_out (1..4)
// PORTS
// clk          in   1                     clock, rising edge
// rst          in   1                     asynchronous, active-low reset
// req          in   NUM_REQ               per-master request; held until that master's done
// req_we       in   NUM_REQ               per-master 1=write, 0=read; valid while req
// req_addr     in   NUM_REQ*ADDR_WIDTH    flattened addresses, master i at [i*AW +: AW]
// req_wdata    in   NUM_REQ*DATA_WIDTH    flattened write data, master i at [i*DW +: DW]
// gnt          out  NUM_REQ               one-hot owner, high from ALEN through COMP
// done         out  NUM_REQ               one-cycle pulse to owner in COMP
// rdata        out  DATA_WIDTH            read data, valid in COMP of a read, held until next read COMP
// bus_ready    out  1                     1 when IDLE (no transfer in flight)
// mem_addr     out  ADDR_WIDTH            memory address
// mem_write_en out  1                     memory write strobe
// mem_read_en  out  1                     memory read strobe
// mem_write_in out  DATA_WIDTH            memory write data
// mem_read_out in   DATA_WIDTH            memory read data
// BEHAVIOUR
// Reset (rst=0, async): state IDLE, rr pointer=0, gnt=0, done=0, rdata=0, bus_ready=1,
//   mem_addr=0, mem_write_en=0, mem_read_en=0, mem_write_in=0, latency counter=0.
//   Reset mid-transfer aborts it: no done, strobes drop immediately, the master must re-request.
// States: IDLE, ALEN, XFER, COMP (one-hot, 4 bits).
// IDLE: if |req -> ALEN; winner = first requester at or after rr pointer (wrapping).
// ALEN (1 cycle): register owner, we, addr, wdata from the winner; gnt=owner; bus_ready=0.
// XFER: write -> mem_write_en=1 for exactly 1 cycle, then COMP.
//   read -> mem_read_en=1 for RD_LAT cycles (counter), then COMP.
// COMP (1 cycle): done[owner]=1; for a read, rdata <= mem_read_out on entry;
//   rr pointer <= owner+1 (mod NUM_REQ). Next: ALEN if any req other than owner (or owner's
//   new req, lowest priority) is high, else IDLE; no idle bubble between back-to-back grants.
// Latency: req seen in IDLE at edge 0 -> ALEN at 1 -> XFER at 2 -> done at 3+RD_LAT-1
//   (write: 3 cycles; read with RD_LAT=1: 3 cycles).
// Owner's request is latched in ALEN: dropping req or changing addr/data mid-transfer has no
//   effect; the transfer completes and done still pulses.
// The owner's req may still be high during COMP (done not yet seen): the arbiter masks it in
//   COMP so one request yields exactly one transfer.
// Simultaneous requests: strictly round-robin; no master waits more than NUM_REQ-1 transfers.
// mem_addr/mem_write_in hold the latched values ALEN..COMP; return to 0 in IDLE.
// mem_write_en and mem_read_en are never high together.
// STRUCTURE
// Shared defines header bus_defs.vh: ADDR_WIDTH/DATA_WIDTH defaults, state one-hot codes.
// Sub-module rr_arbiter: combinational round-robin pick (req, pointer -> one-hot grant);
// the FSM, latches and counter stay in sys_bus_arbiter.
// TESTING
// 1 Single write: m0 req, we=1, addr=0x10, wdata=0xDEADBEEF -> gnt[0] 3 cycles, one write strobe, done[0] at cycle 3.
// 2 Readback: m1 read addr=0x10 after test 1 -> rdata=0xDEADBEEF with done[1]; mem_read_en high RD_LAT cycles.
// 3 Contention: all 4 masters req at once, held -> grants in order 0,1,2,3,0 with no idle cycle between.
// 4 Fairness: m0 re-requests immediately after each done, m2 requests -> m2 served within 1 transfer.
// 5 Req drop: m3 drops req during XFER -> transfer completes, done[3] pulses, next state IDLE.
// 6 Async reset asserted in XFER -> strobes, gnt, done drop before next edge; bus_ready=1, pointer=0.

Source files
------------

// File: rtl/sys_bus_arbiter_pkg.sv
// sys_bus_arbiter_pkg: shared widths and one-hot transfer phase codes for the bus arbiter.
package sys_bus_arbiter_pkg;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ALEN = 4'b0010,
        S_XFER = 4'b0100,
        S_COMP = 4'b1000
    } state_t;
endpackage

// File: rtl/sys_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PW-1:0]      o_idx
);
    logic [PW-1:0] w_cand;
    // Scan from the farthest slot back to the pointer so the nearest requester wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = PW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_gnt = '0;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin sharing of a single-port memory between NUM_REQ masters,
// each transfer sequenced through address-latch, transfer and complete phases.
module sys_bus_arbiter
    import sys_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LAT     = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_bus_ready,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic                          o_mem_write_en,
    output logic                          o_mem_read_en,
    output logic [DATA_WIDTH-1:0]         o_mem_write_in,
    input  logic [DATA_WIDTH-1:0]         i_mem_read_out
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RD_LAT) + 1;

    state_t                r_state, w_next;
    logic [PW-1:0]         r_ptr, r_oidx, w_idx, w_ptr_inc, w_arb_ptr;
    logic [NUM_REQ-1:0]    w_own, w_arb_req, w_arb_gnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [CW-1:0]         r_cnt;
    logic                  w_idle, w_xfer, w_comp, w_xfer_end;

    assign w_idle     = r_state == S_IDLE;
    assign w_xfer     = r_state == S_XFER;
    assign w_comp     = r_state == S_COMP;
    assign w_own      = NUM_REQ'(1) << r_oidx;
    assign w_ptr_inc  = (r_oidx == PW'(NUM_REQ - 1)) ? '0 : r_oidx + PW'(1);
    assign w_xfer_end = r_we || r_cnt == CW'(RD_LAT - 1);
    // In COMP the owner's still-high request is masked and arbitration already uses the
    // advanced pointer, so the next grant follows with no idle bubble.
    assign w_arb_req  = w_comp ? i_req & ~w_own : i_req;
    assign w_arb_ptr  = w_comp ? w_ptr_inc : r_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .i_req (w_arb_req),
        .i_ptr (w_arb_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_COMP: w_next = |w_arb_gnt ? S_ALEN : S_IDLE;
            S_ALEN:         w_next = S_XFER;
            S_XFER:         w_next = w_xfer_end ? S_COMP : S_XFER;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_oidx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_next == S_ALEN) begin
                r_oidx  <= w_idx;
                r_we    <= i_req_we[w_idx];
                r_addr  <= i_req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= i_req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_comp) r_ptr <= w_ptr_inc;
            if (w_comp && !r_we) r_rdata <= i_mem_read_out;
            r_cnt <= (w_xfer && !w_xfer_end) ? r_cnt + CW'(1) : '0;
        end
    end

    assign o_gnt          = w_idle ? '0 : w_own;
    assign o_done         = w_comp ? w_own : '0;
    assign o_bus_ready    = w_idle;
    assign o_mem_addr     = w_idle ? '0 : r_addr;
    assign o_mem_write_in = w_idle ? '0 : r_wdata;
    assign o_mem_write_en = w_xfer && r_we;
    assign o_mem_read_en  = w_xfer && !r_we;
    // Read data becomes valid from memory during COMP; pass it through, then hold it.
    assign o_rdata        = (w_comp && !r_we) ? i_mem_read_out : r_rdata;
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed vector table, corner-case sequences and random traffic
// checked every cycle against a transaction-level reference of the arbiter.
module tb_sys_bus_arbiter;
    localparam int N = 4, AW = 8, DW = 32, RD_LAT = 1;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]      req = '0, req_we = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      gnt, done;
    logic [DW-1:0]     rdata, mem_win, ram_q;
    logic              bus_ready, mem_we, mem_re;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     ram [256];

    always #5 clk = ~clk;

    sys_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_gnt(gnt), .o_done(done),
        .o_rdata(rdata), .o_bus_ready(bus_ready), .o_mem_addr(mem_addr),
        .o_mem_write_en(mem_we), .o_mem_read_en(mem_re), .o_mem_write_in(mem_win),
        .i_mem_read_out(ram_q)
    );

    // Single-port synchronous memory, one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_win;
        if (mem_re) ram_q <= ram[mem_addr];
    end

    // Reference: a transfer is a countdown of its length in cycles (ALEN, XFER..., COMP).
    int          t_left, m_len, m_owner, m_ptr;
    bit          m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_hold;
    logic [31:0] m_mem [256];
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        t_left = 0; m_len = 0; m_ptr = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_hold = 0;
    endtask

    task automatic model_step();
        bit fin;
        int pick, j;
        fin = (t_left == 1);
        pick = -1;
        if (fin && !m_we) m_hold = m_mem[m_addr];
        if (t_left > 0) t_left--;
        if (t_left == 0) begin
            if (fin) m_ptr = (m_owner + 1) % N;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (pick < 0 && req[j] && !(fin && j == m_owner)) pick = j;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_we    = req_we[pick];
                m_addr  = req_addr[pick*AW +: AW];
                m_wdata = req_wdata[pick*DW +: DW];
                m_len   = m_we ? 3 : 2 + RD_LAT;
                t_left  = m_len;
                if (m_we) m_mem[m_addr] = m_wdata;
            end
        end
    endtask

    task automatic check();
        int ph;
        logic [N-1:0] eg;
        ph = m_len - t_left;
        eg = '0;
        if (t_left > 0) eg[m_owner] = 1'b1;
        chk("gnt", gnt, eg);
        chk("done", done, t_left == 1 ? eg : '0);
        chk("bus_ready", bus_ready, t_left == 0);
        chk("mem_write_en", mem_we, t_left > 0 && m_we && ph == 1);
        chk("mem_read_en", mem_re, t_left > 0 && !m_we && ph >= 1 && t_left >= 2);
        chk("mem_addr", mem_addr, t_left > 0 ? m_addr : 8'h0);
        chk("mem_write_in", mem_win, t_left > 0 ? m_wdata : 32'h0);
        chk("rdata", rdata, (t_left == 1 && !m_we) ? m_mem[m_addr] : m_hold);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check();
    endtask

    task automatic serve(input int m, input bit we, input logic [7:0] a, input logic [31:0] d,
                         output int lat, output int rcnt, output logic [31:0] rd);
        bit seen;
        seen = 0; lat = 0; rcnt = 0; rd = '0;
        req_we[m] = we; req_addr[m*AW +: AW] = a; req_wdata[m*DW +: DW] = d; req[m] = 1'b1;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (mem_re) rcnt++;
            if (done[m]) begin seen = 1; rd = rdata; end
        end
        req[m] = 1'b0;
        tick();
    endtask

    function automatic int done_idx();
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (done[i]) r = i;
        return r;
    endfunction

    typedef struct {
        int          m;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [9];
    int   exp_cont [5] = '{0, 1, 2, 3, 0};
    int   exp_fair [3] = '{0, 2, 0};
    int   ord [$];
    int   lat, rcnt, n, d;
    bit   idle_seen, rearm;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = '0; m_mem[i] = '0; end
        ram_q = '0;
        vt[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vt[2] = '{2, 1'b1, 8'hFF, 32'h12345678, 32'h0};
        vt[3] = '{3, 1'b0, 8'hFF, 32'h0,        32'h12345678};
        vt[4] = '{0, 1'b0, 8'h00, 32'h0,        32'h0};
        vt[5] = '{1, 1'b1, 8'h00, 32'hA5A5A5A5, 32'h0};
        vt[6] = '{2, 1'b0, 8'h00, 32'h0,        32'hA5A5A5A5};
        vt[7] = '{3, 1'b1, 8'h10, 32'h00000000, 32'h0};
        vt[8] = '{0, 1'b0, 8'h10, 32'h0,        32'h00000000};

        model_reset();
        @(negedge clk);
        check();
        rst_n = 1'b1;

        // Isolated transactions: latency, strobe count and read data.
        for (int v = 0; v < 9; v++) begin
            serve(vt[v].m, vt[v].we, vt[v].addr, vt[v].wdata, lat, rcnt, rd);
            chk("tbl_latency", lat, vt[v].we ? 3 : 2 + RD_LAT);
            chk("tbl_read_strobes", rcnt, vt[v].we ? 0 : RD_LAT);
            if (!vt[v].we) chk("tbl_rdata", rd, vt[v].exp_rdata);
        end

        // Contention from a fresh pointer: all masters hold their requests.
        rst_n = 1'b0; model_reset(); @(negedge clk); check(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_we[i] = 1'b1; req_addr[i*AW +: AW] = 8'h20 + 8'(i); req_wdata[i*DW +: DW] = 32'(i) + 32'h100;
        end
        req = '1;
        ord.delete(); idle_seen = 0; n = 0;
        while (ord.size() < 5 && n < 40) begin
            tick(); n++;
            if (bus_ready) idle_seen = 1;
            d = done_idx();
            if (d >= 0) ord.push_back(d);
        end
        chk("cont_count", ord.size(), 5);
        for (int k = 0; k < ord.size(); k++) chk("cont_order", ord[k], exp_cont[k]);
        chk("cont_no_idle", idle_seen, 0);
        req = '0; tick(); tick();

        // Fairness: m0 re-requests right after each done while m2 waits.
        req_we[0] = 1'b1; req_addr[0 +: AW] = 8'h30; req_wdata[0 +: DW] = 32'h0F0F0F0F;
        req_we[2] = 1'b0; req_addr[2*AW +: AW] = 8'h21;
        req[0] = 1'b1; tick(); req[2] = 1'b1;
        ord.delete(); rearm = 0; n = 0;
        while (ord.size() < 3 && n < 40) begin
            tick(); n++;
            d = done_idx();
            if (d >= 0) ord.push_back(d);
            if (done[0]) begin req[0] = 1'b0; rearm = 1; end
            else if (rearm) begin req[0] = 1'b1; rearm = 0; end
            if (done[2]) req[2] = 1'b0;
        end
        chk("fair_count", ord.size(), 3);
        for (int k = 0; k < ord.size(); k++) chk("fair_order", ord[k], exp_fair[k]);
        req = '0; tick(); tick();

        // Owner drops its request mid-transfer.
        req_we[3] = 1'b0; req_addr[3*AW +: AW] = 8'h10; req[3] = 1'b1;
        tick(); tick();
        chk("drop_in_xfer", mem_re, 1);
        req[3] = 1'b0; n = 0;
        while (!done[3] && n < 10) begin tick(); n++; end
        chk("drop_done", done, 4'b1000);
        tick();
        chk("drop_idle", bus_ready, 1);

        // Async reset during XFER with a non-zero pointer.
        serve(2, 1'b1, 8'h40, 32'hCAFEF00D, lat, rcnt, rd);
        req_we[1] = 1'b0; req_addr[1*AW +: AW] = 8'h40; req[1] = 1'b1;
        tick(); tick();
        chk("rst_pre_xfer", mem_re, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_read_en", mem_re, 0);
        chk("rst_write_en", mem_we, 0);
        chk("rst_bus_ready", bus_ready, 1);
        chk("rst_mem_addr", mem_addr, 0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        req_we[2] = 1'b0; req_we[3] = 1'b0;
        req[2] = 1'b1; req[3] = 1'b1;
        tick();
        chk("rst_ptr_zero", gnt, 4'b0100);
        n = 0;
        while (req != 0 && n < 40) begin
            tick(); n++;
            for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
        end
        chk("rst_drain", req, 0);
        tick(); tick();

        // Random traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(3) == 0) begin
                    req_we[i] = 1'($urandom_range(1));
                    req_addr[i*AW +: AW] = 8'($urandom_range(7));
                    req_wdata[i*DW +: DW] = $urandom;
                    req[i] = 1'b1;
                end
            end
        end
        n = 0;
        while (req != 0 && n < 40) begin
            tick(); n++;
            for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
        end
        chk("rand_drain", req, 0);
        tick(); tick();
        chk("rand_final_idle", bus_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end
endmodule
